cistern_level_monitor: RTL and testbench
========================================

# cistern_level_monitor

Parametrised cistern water-level monitor: samples N_FLOAT float-switch inputs (thermometer code, bit 0 = lowest float), synchronises and debounces them, decodes the stable code to a binary level, and flags non-thermometer codes as sensor faults while holding the last good level. Sits between the raw float-switch pins and the display/pump-control logic, replacing fixed-width 8-float combinational decoding with a clocked, glitch-tolerant monitor.

## Interface
- N_FLOAT, 8: number of float switches; must be ≥ 2.
- DEB_CYCLES, 16: consecutive identical samples required to accept a code; must be ≥ 1.
- LOW_LVL, 2: low-alarm set threshold.
- HIGH_LVL, 7: high-alarm set threshold; must be > LOW_LVL + HYST.
- HYST, 1: alarm hysteresis in levels; must be ≥ 1.
- LW (derived, not overridable): $clog2(N_FLOAT+1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- floater  in  N_FLOAT  raw float inputs, asynchronous to clk.
- fault_clr  in  1  clears fault_sticky for one-cycle pulse.
- level  out  LW  last accepted valid level (number of submerged floats).
- level_valid  out  1  high once any valid code has been accepted since reset.
- level_chg  out  1  one-cycle pulse when level takes a new value.
- fault  out  1  currently accepted code is not a thermometer code.
- fault_sticky  out  1  latched fault, held until fault_clr.
- low_alarm  out  1  level at/below low threshold (hysteretic).
- high_alarm  out  1  level at/above high threshold (hysteretic).

## Operation
- Synchroniser: two flops per bit; output s.
- Debounce: registers cand (N_FLOAT) and cnt (saturating 0..DEB_CYCLES). Each edge: if s ≠ cand → cand ← s, cnt ← 0; else if cnt < DEB_CYCLES → cnt ← cnt+1. Commit fires on the edge where cnt goes DEB_CYCLES-1 → DEB_CYCLES; exactly one commit per accepted candidate.
- Decode of cand at commit: valid iff cand = 2^k − 1 for some k in 0..N_FLOAT; level value = k.
- FSM states: INIT, NORMAL, FAULT.
  - INIT: level=0, level_valid=0, alarms 0. Valid commit → NORMAL; invalid commit → FAULT.
  - NORMAL: valid commit updates level; level_chg pulses iff value differs. Invalid commit → FAULT.
  - FAULT: fault=1, level and alarms frozen. Valid commit → NORMAL, fault=0, level updated (level_chg if different).
- INIT → first valid commit sets level_valid=1 and pulses level_chg even when k=0.
- fault_sticky: set on every invalid commit; cleared by fault_clr; set wins when both in same cycle.
- Alarms (see Configuration), evaluated on the new level at each valid commit: low_alarm sets at level ≤ LOW_LVL, clears at level ≥ LOW_LVL+HYST; high_alarm sets at level ≥ HIGH_LVL, clears at level ≤ HIGH_LVL−HYST; otherwise hold.

## Timing
- Reset (async assert, sync release): all outputs 0, state INIT, sync flops, cand, cnt = 0.
- Input change stable before edge 1 → outputs update on edge DEB_CYCLES+3.
- Any s change before commit restarts the count; glitches shorter than DEB_CYCLES samples produce no output activity.
- Out of reset with floater=0 held: commit on edge DEB_CYCLES after release.
- Reset mid-debounce discards cand/cnt; no partial commit.
- All outputs registered; level_chg never wider than one cycle.

## Configuration
- CISTERN_LEVEL_ALARM_EN defined: low_alarm/high_alarm logic as above.
- Undefined: alarm logic absent; low_alarm and high_alarm tied to 0; LOW_LVL, HIGH_LVL, HYST unused.

## Test plan
(N_FLOAT=8, DEB_CYCLES=4, LOW_LVL=2, HIGH_LVL=7, HYST=1, macro defined)
- Reset release with floater=8'h00 → edge 4: level_valid=1, level=0, level_chg pulse, low_alarm=1.
- floater 8'h00→8'h0F held → edge 7: level=4, one-cycle level_chg, low_alarm=0.
- floater 8'h0F→8'h1F for 3 cycles then back → level stays 4, no level_chg.
- floater=8'h05 held → fault=1, fault_sticky=1, level=4; then 8'h07 → fault=0, level=3, fault_sticky=1 until fault_clr pulse.
- 8'hFF → level=8, high_alarm=1; 8'h7F → level=7, high_alarm=1; 8'h3F → level=6, high_alarm=0.
- rst asserted during debounce of 8'h03 → all outputs 0 immediately, no commit after release until new count completes.

Source files
------------

// File: rtl/cistern_level_monitor.sv
// cistern_level_monitor: synchronises, debounces and decodes thermometer-coded float switches
// into a binary level with fault flagging. Alarm logic is built only with CISTERN_LEVEL_ALARM_EN.
module cistern_level_monitor #(
  parameter int N_FLOAT    = 8,
  parameter int DEB_CYCLES = 16,
  parameter int LOW_LVL    = 2,
  parameter int HIGH_LVL   = 7,
  parameter int HYST       = 1,
  localparam int LW        = $clog2(N_FLOAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_FLOAT-1:0] floater,
  input  logic               fault_clr,
  output logic [LW-1:0]      level,
  output logic               level_valid,
  output logic               level_chg,
  output logic               fault,
  output logic               fault_sticky,
  output logic               low_alarm,
  output logic               high_alarm
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_NORMAL = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  logic [N_FLOAT-1:0] r_sync1;
  logic [N_FLOAT-1:0] r_s;
  logic [N_FLOAT-1:0] r_cand;
  logic [CW-1:0]      r_cnt;
  state_t             r_state;
  logic [LW-1:0]      r_level;
  logic               r_level_valid;
  logic               r_level_chg;
  logic               r_fault_sticky;

  logic               w_commit;
  logic               w_is_thermo;
  logic [LW-1:0]      w_k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_s     <= '0;
    end else begin
      r_sync1 <= floater;
      r_s     <= r_sync1;
    end
  end

  // cnt saturates at DEB_CYCLES, so the DEB_CYCLES-1 -> DEB_CYCLES step happens once per candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (r_s != r_cand) begin
      r_cand <= r_s;
      r_cnt  <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_commit    = (r_s == r_cand) && (r_cnt == CNT_LAST);
  assign w_is_thermo = ((r_cand & (r_cand + N_FLOAT'(1))) == '0);

  always_comb begin
    w_k = '0;
    for (int i = 0; i < N_FLOAT; i++) begin
      w_k = w_k + LW'(r_cand[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_INIT;
      r_level        <= '0;
      r_level_valid  <= 1'b0;
      r_level_chg    <= 1'b0;
      r_fault_sticky <= 1'b0;
    end else begin
      r_level_chg <= 1'b0;
      if (w_commit) begin
        if (w_is_thermo) begin
          r_state       <= ST_NORMAL;
          r_level       <= w_k;
          r_level_valid <= 1'b1;
          // The first accepted level always announces itself, even when it equals the reset value.
          r_level_chg   <= !r_level_valid || (w_k != r_level);
        end else begin
          r_state <= ST_FAULT;
        end
      end
      if (w_commit && !w_is_thermo) begin
        r_fault_sticky <= 1'b1;
      end else if (fault_clr) begin
        r_fault_sticky <= 1'b0;
      end
    end
  end

  assign level        = r_level;
  assign level_valid  = r_level_valid;
  assign level_chg    = r_level_chg;
  assign fault        = (r_state == ST_FAULT);
  assign fault_sticky = r_fault_sticky;

`ifdef CISTERN_LEVEL_ALARM_EN
  logic        r_low_alarm;
  logic        r_high_alarm;
  logic [31:0] w_k_ext;

  assign w_k_ext = {{(32 - LW){1'b0}}, w_k};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_low_alarm  <= 1'b0;
      r_high_alarm <= 1'b0;
    end else if (w_commit && w_is_thermo) begin
      if (w_k_ext <= 32'(LOW_LVL)) begin
        r_low_alarm <= 1'b1;
      end else if (w_k_ext >= 32'(LOW_LVL + HYST)) begin
        r_low_alarm <= 1'b0;
      end
      if (w_k_ext >= 32'(HIGH_LVL)) begin
        r_high_alarm <= 1'b1;
      end else if (w_k_ext <= 32'(HIGH_LVL - HYST)) begin
        r_high_alarm <= 1'b0;
      end
    end
  end

  assign low_alarm  = r_low_alarm;
  assign high_alarm = r_high_alarm;
`else
  logic [31:0] w_unused_alarm_cfg;
  assign w_unused_alarm_cfg = 32'(LOW_LVL) ^ 32'(HIGH_LVL) ^ 32'(HYST);
  assign low_alarm  = 1'b0;
  assign high_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_cistern_level_monitor.sv
// Bench for cistern_level_monitor: directed test-plan sequence with literal expectations,
// then randomized float patterns checked every cycle against a window-based behavioural model.
module tb_cistern_level_monitor;

  localparam int NF   = 8;
  localparam int DEB  = 4;
  localparam int LOW  = 2;
  localparam int HIGH = 7;
  localparam int HY   = 1;
  localparam int LWB  = $clog2(NF + 1);
`ifdef CISTERN_LEVEL_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NF-1:0]  floater = '0;
  logic           fault_clr = 1'b0;
  logic [LWB-1:0] level;
  logic           level_valid, level_chg, fault, fault_sticky, low_alarm, high_alarm;

  always #5 clk = ~clk;

  cistern_level_monitor #(
    .N_FLOAT(NF), .DEB_CYCLES(DEB), .LOW_LVL(LOW), .HIGH_LVL(HIGH), .HYST(HY)
  ) dut (
    .clk(clk), .rst(rst), .floater(floater), .fault_clr(fault_clr),
    .level(level), .level_valid(level_valid), .level_chg(level_chg),
    .fault(fault), .fault_sticky(fault_sticky),
    .low_alarm(low_alarm), .high_alarm(high_alarm)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Commit rule: the last DEB+1 synchronised samples are identical and the sample before
  // them differs (or precedes reset, where the candidate is an implicit all-zero sample).
  logic [NF-1:0] m_p1 = '0, m_p2 = '0, m_x;
  logic [NF-1:0] m_hist[$] = '{8'h00};
  bit m_commit, m_ok;
  int m_k;
  int m_level = 0;
  bit m_valid = 0, m_chg = 0, m_fault = 0, m_sticky = 0, m_low = 0, m_high = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p1 = '0; m_p2 = '0;
      m_hist = {};
      m_hist.push_back('0);
      m_level = 0; m_valid = 0; m_chg = 0; m_fault = 0; m_sticky = 0; m_low = 0; m_high = 0;
    end else begin
      m_x  = m_p2;
      m_p2 = m_p1;
      m_p1 = floater;
      m_hist.push_back(m_x);
      if (m_hist.size() > DEB + 2) void'(m_hist.pop_front());
      m_commit = 0;
      if (m_hist.size() >= DEB + 1) begin
        m_commit = 1;
        for (int j = 0; j <= DEB; j++)
          if (m_hist[m_hist.size() - 1 - j] != m_x) m_commit = 0;
        if (m_hist.size() >= DEB + 2 && m_hist[m_hist.size() - DEB - 2] == m_x) m_commit = 0;
      end
      m_ok = 0; m_k = 0;
      for (int k = 0; k <= NF; k++)
        if (int'(m_x) == (1 << k) - 1) begin m_ok = 1; m_k = k; end
      m_chg = 0;
      if (m_commit && m_ok) begin
        m_chg   = !m_valid || (m_k != m_level);
        m_level = m_k;
        m_valid = 1;
        m_fault = 0;
        if (ALARM_EN) begin
          if (m_k <= LOW) m_low = 1; else if (m_k >= LOW + HY) m_low = 0;
          if (m_k >= HIGH) m_high = 1; else if (m_k <= HIGH - HY) m_high = 0;
        end
      end else if (m_commit) begin
        m_fault  = 1;
        m_sticky = 1;
      end else if (fault_clr) begin
        m_sticky = 0;
      end
      if (m_commit && m_ok && fault_clr) m_sticky = 0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("level", int'(level), m_level);
    chk("level_valid", int'(level_valid), int'(m_valid));
    chk("level_chg", int'(level_chg), int'(m_chg));
    chk("fault", int'(fault), int'(m_fault));
    chk("fault_sticky", int'(fault_sticky), int'(m_sticky));
    chk("low_alarm", int'(low_alarm), int'(m_low));
    chk("high_alarm", int'(high_alarm), int'(m_high));
  end

  // ---------------- driver tasks ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int r, k, hold;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Out of reset with all floats dry: commit on edge DEB.
    edges(3);
    chk("d_rst_valid_pre", int'(level_valid), 0);
    edges(1);
    chk("d_rst_valid", int'(level_valid), 1);
    chk("d_rst_level", int'(level), 0);
    chk("d_rst_chg", int'(level_chg), 1);
    chk("d_rst_low", int'(low_alarm), ALARM_EN ? 1 : 0);
    edges(1);
    chk("d_rst_chg_off", int'(level_chg), 0);

    // 00 -> 0F: new level on the DEB+3rd edge after the change.
    floater = 8'h0F;
    edges(6);
    chk("d_0f_level_pre", int'(level), 0);
    edges(1);
    chk("d_0f_level", int'(level), 4);
    chk("d_0f_chg", int'(level_chg), 1);
    chk("d_0f_low", int'(low_alarm), 0);
    edges(1);
    chk("d_0f_chg_off", int'(level_chg), 0);

    // Short glitch to 1F is filtered out.
    floater = 8'h1F;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) floater = 8'h0F;
      edges(1);
      chk("d_glitch_level", int'(level), 4);
      chk("d_glitch_chg", int'(level_chg), 0);
    end

    // Non-thermometer code: fault with level frozen, then recovery.
    floater = 8'h05;
    edges(8);
    chk("d_f05_fault", int'(fault), 1);
    chk("d_f05_sticky", int'(fault_sticky), 1);
    chk("d_f05_level", int'(level), 4);
    floater = 8'h07;
    edges(8);
    chk("d_07_fault", int'(fault), 0);
    chk("d_07_level", int'(level), 3);
    chk("d_07_sticky", int'(fault_sticky), 1);
    fault_clr = 1'b1;
    edges(1);
    fault_clr = 1'b0;
    chk("d_clr_sticky", int'(fault_sticky), 0);

    // High alarm with hysteresis.
    floater = 8'hFF;
    edges(8);
    chk("d_ff_level", int'(level), 8);
    chk("d_ff_high", int'(high_alarm), ALARM_EN ? 1 : 0);
    floater = 8'h7F;
    edges(8);
    chk("d_7f_level", int'(level), 7);
    chk("d_7f_high", int'(high_alarm), ALARM_EN ? 1 : 0);
    floater = 8'h3F;
    edges(8);
    chk("d_3f_level", int'(level), 6);
    chk("d_3f_high", int'(high_alarm), 0);

    // Reset in the middle of debouncing 03.
    floater = 8'h03;
    edges(4);
    #2 rst = 1'b1;
    #1;
    chk("d_mid_rst_level", int'(level), 0);
    chk("d_mid_rst_valid", int'(level_valid), 0);
    chk("d_mid_rst_high", int'(high_alarm), 0);
    chk("d_mid_rst_low", int'(low_alarm), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    edges(6);
    chk("d_post_rst_valid_pre", int'(level_valid), 0);
    edges(1);
    chk("d_post_rst_level", int'(level), 2);
    chk("d_post_rst_valid", int'(level_valid), 1);
    chk("d_post_rst_chg", int'(level_chg), 1);
    chk("d_post_rst_low", int'(low_alarm), ALARM_EN ? 1 : 0);

    // Randomized patterns: thermometer codes, arbitrary codes, single-bit glitches.
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        k = $urandom_range(0, NF);
        floater = NF'((1 << k) - 1);
      end else if (r < 8) begin
        floater = NF'($urandom);
      end else begin
        floater = floater ^ NF'(1 << $urandom_range(0, NF - 1));
      end
      hold = $urandom_range(1, DEB + 6);
      for (int h = 0; h < hold; h++) begin
        fault_clr = ($urandom_range(0, 15) == 0);
        edges(1);
      end
      fault_clr = 1'b0;
      if ($urandom_range(0, 79) == 0) pulse_reset();
    end

    edges(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
